// File: rtl/axi_i2c_cmd_slave.sv
// AXI4-Lite slave front-end for the I2C bridge: queues reads/writes as ordered commands,
// tracks outstanding responses, times out stalled reads and exposes a W1C status word.
module axi_i2c_cmd_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RD_TIMEOUT = 1024,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 'hFFFC
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic                  CMD_RNW,
  output logic [ADDR_WIDTH-1:0] CMD_ADDR,
  output logic [DATA_WIDTH-1:0] CMD_WDATA,
  input  logic                  RSP_VALID,
  input  logic [DATA_WIDTH-1:0] RSP_DATA,
  input  logic                  RSP_ERR
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int OUT_W = PTR_W + 2;
  localparam int TMR_W = $clog2(RD_TIMEOUT);
  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} wState_t;
  typedef enum logic [1:0] {R_IDLE, R_ENQ, R_WAIT, R_RESP} rState_t;

  wState_t r_wState;
  rState_t r_rState;
  logic r_awHeld, r_wHeld;
  logic [ADDR_WIDTH-1:0] r_awAddr, r_arAddr;
  logic [DATA_WIDTH-1:0] r_wData, r_rData;
  logic [1:0] r_rResp;
  logic [TMR_W-1:0] r_timer;
  logic [ENT_W-1:0] r_mem [CMD_DEPTH];
  logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [LVL_W-1:0] r_level;
  logic [OUT_W-1:0] r_outstanding;
  logic r_wrNack, r_rdNack, r_rdTo;

  logic w_full, w_empty, w_cmdValid, w_pop, w_push;
  logic w_awHit, w_wHit, w_wrIsStatus, w_wrPush, w_wrClear, w_rdPush;
  logic w_rspTake, w_rdRsp, w_rdTimeout;
  logic [ENT_W-1:0] w_pushData, w_head;
  logic [31:0] w_status;

  assign w_full       = (r_level == LVL_W'(CMD_DEPTH));
  assign w_empty      = (r_level == '0);
  assign w_cmdValid   = !w_empty && (r_outstanding != OUT_W'(2 * CMD_DEPTH));
  assign w_pop        = w_cmdValid && CMD_READY;
  assign w_awHit      = (r_wState == W_IDLE) && AWVALID && !r_awHeld;
  assign w_wHit       = (r_wState == W_IDLE) && WVALID && !r_wHeld;
  assign w_wrIsStatus = (r_awAddr == STATUS_ADDR);
  assign w_wrPush     = (r_wState == W_PUSH) && !w_wrIsStatus && !w_full;
  assign w_wrClear    = (r_wState == W_PUSH) && w_wrIsStatus;
  // The write FSM owns the single push port; a colliding read retries next cycle.
  assign w_rdPush     = (r_rState == R_ENQ) && !w_full && !w_wrPush;
  assign w_push       = w_wrPush || w_rdPush;
  assign w_pushData   = w_wrPush ? {1'b0, r_awAddr, r_wData} : {1'b1, r_arAddr, {DATA_WIDTH{1'b0}}};
  assign w_head       = r_mem[r_rdPtr];
  assign w_rspTake    = RSP_VALID && (r_outstanding != '0);
  assign w_rdRsp      = (r_rState == R_WAIT) && RSP_VALID && (r_outstanding == OUT_W'(1)) && w_empty;
  assign w_rdTimeout  = (r_rState == R_WAIT) && !w_rdRsp && (r_timer == TMR_W'(RD_TIMEOUT - 1));
  assign w_status     = {8'h00, 8'(r_outstanding), 8'(r_level), 5'b0, r_rdTo, r_rdNack, r_wrNack};

  assign AWREADY   = ARESETn && (r_wState == W_IDLE) && !r_awHeld;
  assign WREADY    = ARESETn && (r_wState == W_IDLE) && !r_wHeld;
  assign ARREADY   = ARESETn && (r_rState == R_IDLE);
  assign BVALID    = (r_wState == W_RESP);
  assign BRESP     = 2'b00;
  assign RVALID    = (r_rState == R_RESP);
  assign RDATA     = r_rData;
  assign RRESP     = r_rResp;
  assign CMD_VALID = w_cmdValid;
  assign CMD_RNW   = w_cmdValid && w_head[ENT_W-1];
  assign CMD_ADDR  = w_cmdValid ? w_head[ENT_W-2:DATA_WIDTH] : '0;
  assign CMD_WDATA = w_cmdValid ? w_head[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wrPtr] <= w_pushData;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      case ({w_pop, w_rspTake})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wState <= W_IDLE;
      r_awHeld <= 1'b0;
      r_wHeld <= 1'b0;
      r_awAddr <= '0;
      r_wData <= '0;
    end else begin
      case (r_wState)
        W_IDLE: begin
          if (w_awHit) begin
            r_awAddr <= AWADDR;
            r_awHeld <= 1'b1;
          end
          if (w_wHit) begin
            r_wData <= WDATA;
            r_wHeld <= 1'b1;
          end
          if ((r_awHeld || w_awHit) && (r_wHeld || w_wHit)) r_wState <= W_PUSH;
        end
        W_PUSH: if (w_wrClear || w_wrPush) r_wState <= W_RESP;
        W_RESP: begin
          if (BREADY) begin
            r_wState <= W_IDLE;
            r_awHeld <= 1'b0;
            r_wHeld <= 1'b0;
          end
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rState <= R_IDLE;
      r_arAddr <= '0;
      r_rData <= '0;
      r_rResp <= 2'b00;
      r_timer <= '0;
    end else begin
      case (r_rState)
        R_IDLE: begin
          if (ARVALID) begin
            if (ARADDR == STATUS_ADDR) begin
              r_rData <= DATA_WIDTH'(w_status);
              r_rResp <= 2'b00;
              r_rState <= R_RESP;
            end else begin
              r_arAddr <= ARADDR;
              r_rState <= R_ENQ;
            end
          end
        end
        R_ENQ: begin
          if (w_rdPush) begin
            r_timer <= '0;
            r_rState <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (w_rdRsp) begin
            r_rData <= RSP_DATA;
            r_rResp <= RSP_ERR ? 2'b10 : 2'b00;
            r_rState <= R_RESP;
          end else if (w_rdTimeout) begin
            r_rData <= '0;
            r_rResp <= 2'b10;
            r_rState <= R_RESP;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        R_RESP: if (RREADY) r_rState <= R_IDLE;
        default: r_rState <= R_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear survives.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wrNack <= 1'b0;
      r_rdNack <= 1'b0;
      r_rdTo <= 1'b0;
    end else begin
      r_wrNack <= (RSP_VALID && RSP_ERR && !w_rdRsp) || (r_wrNack && !(w_wrClear && r_wData[0]));
      r_rdNack <= (w_rdRsp && RSP_ERR) || (r_rdNack && !(w_wrClear && r_wData[1]));
      r_rdTo <= w_rdTimeout || (r_rdTo && !(w_wrClear && r_wData[2]));
    end
  end

endmodule
